// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Optional trailer checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  // Loader FSM states; CSUM is only reachable when the checksum trailer is built in.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam int LEN_W_DEFAULT  = 32;

  // States in which the loader pulls bytes off the link and reports itself busy.
  function automatic logic state_takes_bytes(input loader_state_t s);
    return (s == LEN) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// Collects four accepted bytes into one little-endian 32-bit word.
// Used both for the length header and for every instruction word.
// Optional checksum feature (IMEM_LOADER_CHECKSUM_EN) does not affect this block.
module byte_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]        byte_cnt;
  logic [WORD_W-9:0] partial;

  // Earlier bytes shift down from the top so the first byte ends up in [7:0].
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt <= 2'd0;
      partial  <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      partial  <= {byte_in, partial[WORD_W-9:8]};
    end
  end

  // The fourth byte completes the word in the same cycle it is accepted.
  always_comb begin
    word_valid = byte_valid && (byte_cnt == 2'd3);
    word       = {byte_in, partial};
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length header plus image bytes over a valid/ready
// link, writes words into instruction memory from address 0 and releases the
// core once the image is complete.
// Define IMEM_LOADER_CHECKSUM_EN to require an 8-bit checksum trailer byte.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = LEN_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Capacity of the instruction memory expressed in the header's width.
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(64'd1 << ADDR_W);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_DATA = CSUM;
`else
  localparam loader_state_t AFTER_DATA = DONE;
`endif

  loader_state_t     state;
  loader_state_t     state_next;
  logic              byte_accept;
  logic              asm_valid;
  logic              restart;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic [LEN_W-1:0]  len_word;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   word_cnt_inc;
  logic [ADDR_W:0]   len_reg;
  logic              word_last;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic [7:0] csum_total;
`endif

  // Handshake and bookkeeping decoded from the current registered state.
  always_comb begin
    byte_accept  = rx_valid && rx_ready;
    asm_valid    = byte_accept && ((state == LEN) || (state == DATA));
    restart      = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    len_word     = word[LEN_W-1:0];
    word_cnt_inc = word_cnt + 1'b1;
    word_last    = (word_cnt_inc == len_reg);
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running sum plus the trailer must wrap to zero for a good image.
  always_comb begin
    csum_total = csum + rx_data;
  end
`endif

  byte_word_assembler u_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .byte_valid (asm_valid),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next-state selection; outputs are registered from this below.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = LEN;
      end
      LEN: begin
        if (word_valid) begin
          if (len_word == '0)
            state_next = AFTER_DATA;
          else if (len_word > DEPTH_L)
            state_next = ERR;
          else
            state_next = DATA;
        end
      end
      DATA: begin
        if (word_valid && word_last) state_next = AFTER_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (byte_accept) state_next = (csum_total == 8'h00) ? DONE : ERR;
      end
`endif
      DONE, ERR: begin
        if (start) state_next = LEN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Loader FSM: state, counters and all registered outputs advance together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_cnt   <= '0;
      len_reg    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      state      <= state_next;
      rx_ready   <= state_takes_bytes(state_next);
      busy       <= state_takes_bytes(state_next);
      done       <= (state_next == DONE);
      error      <= (state_next == ERR);
      core_reset <= !((state == DONE) && (state_next == DONE));
      imem_we    <= 1'b0;

      if (restart) begin
        word_cnt <= '0;
        len_reg  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= 8'h00;
`endif
      end

      if ((state == LEN) && word_valid)
        len_reg <= len_word[ADDR_W:0];

      if ((state == DATA) && word_valid) begin
        imem_we    <= 1'b1;
        imem_addr  <= word_cnt[ADDR_W-1:0];
        imem_wdata <= word;
        word_cnt   <= word_cnt_inc;
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      if ((state == DATA) && byte_accept)
        csum <= csum + rx_data;
`endif
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader.
// Also covers the checksum trailer when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_boot_loader;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic              error;

  int          checkCount = 0;
  int          passCount  = 0;
  int          cycle      = 0;
  int          lastWeCycle = -1;
  int          fallCycle   = -1;
  logic        prevCoreReset = 1'b1;
  logic [31:0] writeAddr[$];
  logic [31:0] writeData[$];
  logic [7:0]  benchSum;

  imem_boot_loader #(.ADDR_W(ADDR_W), .LEN_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time core_reset release against the last write.
  always @(posedge clk) cycle <= cycle + 1;

  // Record every memory write and the cycle core_reset drops.
  always @(negedge clk) begin
    if (imem_we) begin
      writeAddr.push_back(32'(imem_addr));
      writeData.push_back(imem_wdata);
      lastWeCycle = cycle;
    end
    if (prevCoreReset && !core_reset) fallCycle = cycle;
    prevCoreReset = core_reset;
  end

  // Global guard so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  // Offer one byte and hold it until the loader takes it.
  task automatic applyStimulus(input logic [7:0] b);
    int waitCycles = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!rx_ready) checkOutput("rxReadyTimeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(w[8*i +: 8]);
      benchSum = benchSum + w[8*i +: 8];
    end
  endtask

  task automatic sendHeader(input logic [31:0] n);
    for (int i = 0; i < 4; i++) applyStimulus(n[8*i +: 8]);
    benchSum = 8'h00;
  endtask

  // Trailer that makes the image checksum wrap to zero.
  task automatic sendGoodTrailer();
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(8'h00 - benchSum);
`endif
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic clearLog();
    writeAddr.delete();
    writeData.delete();
    lastWeCycle = -1;
    fallCycle   = -1;
  endtask

  // Wait (bounded) until the load finishes one way or the other.
  task automatic waitOutcome(input string tag);
    int n = 0;
    @(negedge clk);
    while (!(done || error) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(done || error)) checkOutput({tag, "Timeout"}, 32'(done | error), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] patternWord(input int i);
    return 32'h1357_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  task automatic checkTwoWordImage(input string tag);
    checkOutput({tag, "Writes"}, 32'(writeData.size()), 32'd2);
    if (writeData.size() == 2) begin
      checkOutput({tag, "Addr0"}, writeAddr[0], 32'd0);
      checkOutput({tag, "Data0"}, writeData[0], 32'h00A00513);
      checkOutput({tag, "Addr1"}, writeAddr[1], 32'd1);
      checkOutput({tag, "Data1"}, writeData[1], 32'h00100593);
    end
    checkOutput({tag, "Done"}, 32'(done), 32'd1);
    checkOutput({tag, "CoreReset"}, 32'(core_reset), 32'd0);
    checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    checkOutput({tag, "ReleaseDelay"}, 32'(fallCycle - lastWeCycle), 32'd1);
`endif
  endtask

  initial begin
    int gapBad;
    int badWords;

    reset    = 1'b1;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    benchSum = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    // Reset values while reset is held.
    checkOutput("rstRxReady",   32'(rx_ready),   32'd0);
    checkOutput("rstWe",        32'(imem_we),    32'd0);
    checkOutput("rstAddr",      32'(imem_addr),  32'd0);
    checkOutput("rstWdata",     imem_wdata,      32'd0);
    checkOutput("rstCoreReset", 32'(core_reset), 32'd1);
    checkOutput("rstBusy",      32'(busy),       32'd0);
    checkOutput("rstDone",      32'(done),       32'd0);
    checkOutput("rstError",     32'(error),      32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Start in IDLE with a byte already offered: that byte must not be consumed.
    $display("[TB] two-word image");
    clearLog();
    rx_data  = 8'hFF;
    rx_valid = 1'b1;
    pulseStart();
    rx_valid = 1'b0;
    checkOutput("startBusy",    32'(busy),       32'd1);
    checkOutput("startRxReady", 32'(rx_ready),   32'd1);
    sendHeader(32'd2);
    sendWord(32'h00A00513);
    sendWord(32'h00100593);
    sendGoodTrailer();
    waitOutcome("img1");
    checkTwoWordImage("img1");

    // Restart from DONE, with a five-cycle stall in the middle of word 0.
    $display("[TB] two-word image with stall");
    clearLog();
    pulseStart();
    checkOutput("restartCoreReset", 32'(core_reset), 32'd1);
    checkOutput("restartBusy",      32'(busy),       32'd1);
    checkOutput("restartDone",      32'(done),       32'd0);
    sendHeader(32'd2);
    applyStimulus(8'h13);
    benchSum = benchSum + 8'h13;
    applyStimulus(8'h05);
    benchSum = benchSum + 8'h05;
    gapBad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!rx_ready || imem_we) gapBad++;
      @(posedge clk);
      #1;
    end
    checkOutput("gapReadyHeld", 32'(gapBad), 32'd0);
    applyStimulus(8'hA0);
    benchSum = benchSum + 8'hA0;
    applyStimulus(8'h00);
    sendWord(32'h00100593);
    sendGoodTrailer();
    waitOutcome("img2");
    checkTwoWordImage("img2");

    // Empty image: straight to DONE with no writes.
    $display("[TB] empty image");
    clearLog();
    pulseStart();
    sendHeader(32'd0);
    sendGoodTrailer();
    waitOutcome("empty");
    checkOutput("emptyWrites",    32'(writeData.size()), 32'd0);
    checkOutput("emptyDone",      32'(done),             32'd1);
    checkOutput("emptyCoreReset", 32'(core_reset),       32'd0);

    // Oversized header is rejected.
    $display("[TB] oversized header");
    clearLog();
    pulseStart();
    sendHeader(32'd257);
    waitOutcome("n257");
    checkOutput("n257Error",     32'(error),            32'd1);
    checkOutput("n257Done",      32'(done),             32'd0);
    checkOutput("n257Writes",    32'(writeData.size()), 32'd0);
    checkOutput("n257CoreReset", 32'(core_reset),       32'd1);
    checkOutput("n257Busy",      32'(busy),             32'd0);

    // Full-capacity image from the ERR state.
    $display("[TB] full-capacity image");
    clearLog();
    pulseStart();
    checkOutput("errRestartError", 32'(error), 32'd0);
    sendHeader(32'd256);
    for (int i = 0; i < 256; i++) sendWord(patternWord(i));
    sendGoodTrailer();
    waitOutcome("n256");
    checkOutput("n256Writes", 32'(writeData.size()), 32'd256);
    badWords = 0;
    for (int i = 0; i < writeData.size(); i++)
      if (writeAddr[i] != 32'(i) || writeData[i] != patternWord(i)) badWords++;
    checkOutput("n256BadWords", 32'(badWords), 32'd0);
    if (writeAddr.size() > 0) checkOutput("n256LastAddr", writeAddr[writeAddr.size()-1], 32'h0000_00FF);
    checkOutput("n256Done", 32'(done), 32'd1);

    // Reset mid-load, then a clean single-word image.
    $display("[TB] reset mid-load");
    pulseStart();
    sendHeader(32'd2);
    for (int i = 0; i < 6; i++) applyStimulus(8'h11 * 8'(i + 1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midRstCoreReset", 32'(core_reset), 32'd1);
    checkOutput("midRstBusy",      32'(busy),       32'd0);
    checkOutput("midRstRxReady",   32'(rx_ready),   32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clearLog();
    pulseStart();
    sendHeader(32'd1);
    sendWord(32'hDEADBEEF);
    sendGoodTrailer();
    waitOutcome("n1");
    checkOutput("n1Writes", 32'(writeData.size()), 32'd1);
    if (writeData.size() == 1) begin
      checkOutput("n1Addr", writeAddr[0], 32'd0);
      checkOutput("n1Data", writeData[0], 32'hDEADBEEF);
    end
    checkOutput("n1Done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum trailer: 01+02+03+04 = 0A, so F6 is good and F7 is bad.
    $display("[TB] checksum trailer");
    clearLog();
    pulseStart();
    sendHeader(32'd1);
    sendWord(32'h04030201);
    applyStimulus(8'hF6);
    waitOutcome("csumGood");
    checkOutput("csumGoodDone",  32'(done),  32'd1);
    checkOutput("csumGoodError", 32'(error), 32'd0);
    clearLog();
    pulseStart();
    sendHeader(32'd1);
    sendWord(32'h04030201);
    applyStimulus(8'hF7);
    waitOutcome("csumBad");
    checkOutput("csumBadError",     32'(error),            32'd1);
    checkOutput("csumBadCoreReset", 32'(core_reset),       32'd1);
    checkOutput("csumBadWrites",    32'(writeData.size()), 32'd1);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
